hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage core. It produces the PC/IF-ID hold signal (`hd_o`, wired to the PC register's hazard-hold input), the ID/EX bubble, and a whole-pipe freeze for multi-cycle data-memory accesses. Hazard detection is combinational so a stall takes effect at the very next edge. A wait-state FSM tracks outstanding memory accesses, enforces a timeout, and maintains a stall-cycle counter.

---
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline-side bundle for the hazard/stall controller. It carries
//               the ID/EX hazard operands, the MEM handshake and the stall outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        id_rs1_use_i;
    logic        id_rs2_use_i;
    logic        ex_memread_i;
    logic [4:0]  ex_rd_i;
    logic        mem_req_i;
    logic        mem_ack_i;
    logic        hd_o;
    logic        bubble_o;
    logic        freeze_o;
    logic        err_o;
    logic [31:0] stall_cnt_o;

    // Controller side
    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
        input  ex_memread_i, ex_rd_i, mem_req_i, mem_ack_i,
        output hd_o, bubble_o, freeze_o, err_o, stall_cnt_o
    );

    // Pipeline side
    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
        output ex_memread_i, ex_rd_i, mem_req_i, mem_ack_i,
        input  hd_o, bubble_o, freeze_o, err_o, stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use hazard detection plus a memory wait-state FSM that
//               freezes the pipe, times out into a sticky error and counts stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  wire logic    clk_i,
    input  wire logic    rst_n_i,
    input  wire logic    start_i,
    hazard_ctrl_if.slave bus
);

    localparam logic [1:0]  c_S_IDLE    = 2'd0;
    localparam logic [1:0]  c_S_WAIT    = 2'd1;
    localparam logic [1:0]  c_S_ERR     = 2'd2;
    localparam logic [7:0]  c_WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] c_CNT_MAX   = 32'hFFFF_FFFF;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
    logic        r_err;
    logic        w_err_nxt;
    logic [31:0] r_stall_cnt;
    logic [31:0] w_stall_cnt_nxt;

    logic        w_rs1_hit;
    logic        w_rs2_hit;
    logic        w_lu;
    logic        w_freeze_raw;
    logic        w_freeze;
    logic        w_hd;
    logic        w_bubble;

    always_comb begin
        w_rs1_hit = bus.id_rs1_use_i && (bus.id_rs1_i == bus.ex_rd_i);
        w_rs2_hit = bus.id_rs2_use_i && (bus.id_rs2_i == bus.ex_rd_i);
        w_lu      = bus.ex_memread_i && (bus.ex_rd_i != 5'd0) && (w_rs1_hit || w_rs2_hit);
    end

    // A request acked in its own cycle never freezes; in WAIT the request is implied.
    always_comb begin
        w_freeze_raw = 1'b0;
        case (r_state)
            c_S_IDLE: w_freeze_raw = bus.mem_req_i && !bus.mem_ack_i;
            c_S_WAIT: w_freeze_raw = !bus.mem_ack_i;
            c_S_ERR:  w_freeze_raw = 1'b1;
            default:  w_freeze_raw = 1'b0;
        endcase
    end

    always_comb begin
        w_freeze = start_i && w_freeze_raw;
        w_hd     = start_i && (w_freeze_raw || (w_lu && (r_state != c_S_ERR)));
        w_bubble = start_i && w_lu && !w_freeze_raw;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_err_nxt       = r_err;
        w_stall_cnt_nxt = r_stall_cnt;
        if (!start_i) begin
            w_state_nxt     = c_S_IDLE;
            w_wait_cnt_nxt  = 8'd0;
            w_err_nxt       = 1'b0;
            w_stall_cnt_nxt = 32'd0;
        end else begin
            if (w_hd && (r_stall_cnt != c_CNT_MAX)) begin
                w_stall_cnt_nxt = r_stall_cnt + 32'd1;
            end
            case (r_state)
                c_S_IDLE: begin
                    if (bus.mem_req_i && !bus.mem_ack_i) begin
                        w_state_nxt    = c_S_WAIT;
                        w_wait_cnt_nxt = 8'd1;
                    end else begin
                        w_wait_cnt_nxt = 8'd0;
                    end
                end
                c_S_WAIT: begin
                    if (bus.mem_ack_i) begin
                        w_state_nxt    = c_S_IDLE;
                        w_wait_cnt_nxt = 8'd0;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        w_state_nxt = c_S_ERR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    end
                end
                c_S_ERR: begin
                    w_state_nxt = c_S_ERR;
                end
                default: begin
                    w_state_nxt    = c_S_IDLE;
                    w_wait_cnt_nxt = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= c_S_IDLE;
            r_wait_cnt  <= 8'd0;
            r_err       <= 1'b0;
            r_stall_cnt <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_err       <= w_err_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    assign bus.hd_o        = w_hd;
    assign bus.bubble_o    = w_bubble;
    assign bus.freeze_o    = w_freeze;
    assign bus.err_o       = r_err;
    assign bus.stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl: directed scenarios plus random
//               traffic checked against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;

    typedef struct {
        logic        hd;
        logic        bubble;
        logic        freeze;
        logic        err;
        logic [31:0] stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    hazard_ctrl_if u_if ();

    hazard_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .bus     (u_if)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural model: an access is "pending" once it has frozen at least one cycle.
    bit          m_pending = 1'b0;
    int          m_frozen  = 0;
    bit          m_err     = 1'b0;
    logic [31:0] m_stall   = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending = 1'b0;
        m_frozen  = 0;
        m_err     = 1'b0;
        m_stall   = 32'd0;
    endtask

    task automatic cycle(input bit st, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2, input bit mr, input logic [4:0] rd,
                         input bit req, input bit ack);
        exp_t e;
        bit   lu;
        bit   fr;
        bit   hd;
        @(negedge clk);
        start              = st;
        u_if.id_rs1_i      = rs1;
        u_if.id_rs2_i      = rs2;
        u_if.id_rs1_use_i  = u1;
        u_if.id_rs2_use_i  = u2;
        u_if.ex_memread_i  = mr;
        u_if.ex_rd_i       = rd;
        u_if.mem_req_i     = req;
        u_if.mem_ack_i     = ack;
        e.err   = m_err;
        e.stall = m_stall;
        if (!st) begin
            e.hd = 1'b0; e.bubble = 1'b0; e.freeze = 1'b0;
            model_reset();
        end else begin
            lu = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
            if (m_err)          fr = 1'b1;
            else if (m_pending) fr = !ack;
            else                fr = req && !ack;
            hd       = fr || (lu && !m_err);
            e.hd     = hd;
            e.bubble = lu && !fr;
            e.freeze = fr;
            if (hd && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (!m_err) begin
                if (m_pending) begin
                    if (ack) begin
                        m_pending = 1'b0;
                        m_frozen  = 0;
                    end else begin
                        m_frozen++;
                        if (m_frozen == TIMEOUT) begin
                            m_err     = 1'b1;
                            m_pending = 1'b0;
                        end
                    end
                end else if (req && !ack) begin
                    m_pending = 1'b1;
                    m_frozen  = 1;
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset with random inputs applied; nothing is scored while held.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start             = 1'($urandom);
            u_if.id_rs1_i     = 5'($urandom);
            u_if.id_rs2_i     = 5'($urandom);
            u_if.id_rs1_use_i = 1'($urandom);
            u_if.id_rs2_use_i = 1'($urandom);
            u_if.ex_memread_i = 1'($urandom);
            u_if.ex_rd_i      = 5'($urandom);
            u_if.mem_req_i    = 1'($urandom);
            u_if.mem_ack_i    = 1'($urandom);
        end
        @(negedge clk);
        start             = 1'b1;
        u_if.id_rs1_use_i = 1'b0;
        u_if.id_rs2_use_i = 1'b0;
        u_if.ex_memread_i = 1'b0;
        u_if.mem_req_i    = 1'b0;
        u_if.mem_ack_i    = 1'b0;
        rst_n             = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("hd_o",        {31'd0, u_if.hd_o},     {31'd0, e.hd});
                check("bubble_o",    {31'd0, u_if.bubble_o}, {31'd0, e.bubble});
                check("freeze_o",    {31'd0, u_if.freeze_o}, {31'd0, e.freeze});
                check("err_o",       {31'd0, u_if.err_o},    {31'd0, e.err});
                check("stall_cnt_o", u_if.stall_cnt_o,       e.stall);
            end
        end
    end

    initial begin : stimulus
        u_if.id_rs1_i = 0; u_if.id_rs2_i = 0; u_if.id_rs1_use_i = 0; u_if.id_rs2_use_i = 0;
        u_if.ex_memread_i = 0; u_if.ex_rd_i = 0; u_if.mem_req_i = 0; u_if.mem_ack_i = 0;

        do_reset();
        idle(2);

        // Load-use, then the two non-hazard variants
        cycle(1, 5'd1, 5'd5, 0, 1, 1, 5'd5, 0, 0);
        idle(1);
        cycle(1, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0);
        cycle(1, 5'd1, 5'd5, 0, 0, 1, 5'd5, 0, 0);
        cycle(1, 5'd7, 5'd2, 1, 0, 1, 5'd7, 0, 0);
        idle(1);

        // Memory wait with ack on the 4th cycle, then a zero-wait access
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);

        // Timeout, late ack ignored, then start low clears everything
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle(1, 5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Load-use during a 2-cycle memory wait
        cycle(1, 5'd4, 5'd0, 1, 0, 1, 5'd4, 1, 0);
        cycle(1, 5'd4, 5'd0, 1, 0, 1, 5'd4, 0, 0);
        cycle(1, 5'd4, 5'd0, 1, 0, 1, 5'd4, 0, 1);
        idle(1);

        // Reset while in WAIT abandons the access
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        idle(2);

        // Saturation near the top of the counter
        idle(1);
        #3;
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        m_stall = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) cycle(1, 5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 0);
        idle(1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic with small register indices so hazards are frequent
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom % 25) != 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)),
                  ($urandom % 3) == 0, ($urandom % 3) == 0);
        end

        @(negedge clk);
        #5;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
